// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset sequencer with shared memory port and timeout
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Function_opcode,
    input  logic        mem_ready,
    input  logic        halt,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        reg_write,
    output logic        pc_write,
    output logic [2:0]  state,
    output logic        bus_err,
    output logic [31:0] instr_count
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q;
    logic          bus_err_q;
    logic [31:0]   count_q;

    logic rd_c, wr_c, sel_c, ir_c, reg_c, pc_c;

    // Opcode classes of the supported subset
    logic is_r, is_jr, is_j, is_jal, is_br, is_lw, is_sw, is_i, known;
    assign is_r   = (Opcode == 6'h00);
    assign is_jr  = is_r && (Function_opcode == 6'h08);
    assign is_j   = (Opcode == 6'h02);
    assign is_jal = (Opcode == 6'h03);
    assign is_br  = (Opcode == 6'h04) || (Opcode == 6'h05);
    assign is_lw  = (Opcode == 6'h23);
    assign is_sw  = (Opcode == 6'h2B);
    assign is_i   = (Opcode[5:3] == 3'b001);
    assign known  = is_r || is_j || is_jal || is_br || is_lw || is_sw || is_i;

    logic timeout;
    assign timeout = !mem_ready && (wait_q == WAIT_LAST);

    // State register, wait counter, sticky error and retire counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_q <= '0;
            else if ((rd_c || wr_c) && !mem_ready)
                wait_q <= wait_q + 1'b1;
            if (state_d == S_ERR)
                bus_err_q <= 1'b1;
            if (pc_c)
                count_q <= count_q + 32'd1;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        sel_c   = 1'b0;
        ir_c    = 1'b0;
        reg_c   = 1'b0;
        pc_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!halt) begin
                    rd_c = 1'b1;
                    if (mem_ready) begin
                        ir_c    = 1'b1;
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DECODE: begin
                // jr is an R-type, so it must be tested before the generic R path
                if (is_j || is_jr || !known) begin
                    pc_c    = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_c    = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                sel_c = 1'b1;
                rd_c  = is_lw;
                wr_c  = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_c    = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_c   = 1'b1;
                pc_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are held low for as long as reset is asserted
    assign mem_read     = rd_c  & ~reset;
    assign mem_write    = wr_c  & ~reset;
    assign mem_addr_sel = sel_c & ~reset;
    assign ir_write     = ir_c  & ~reset;
    assign reg_write    = reg_c & ~reset;
    assign pc_write     = pc_c  & ~reset;

    assign state       = state_q;
    assign bus_err     = bus_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int K_JMP = 0, K_JAL = 1, K_BR = 2, K_ALU = 3, K_LW = 4, K_SW = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Function_opcode = '0;
    logic        mem_ready = 1'b0;
    logic        halt = 1'b0;
    logic        mem_read, mem_write, mem_addr_sel, ir_write, reg_write, pc_write;
    logic [2:0]  state;
    logic        bus_err;
    logic [31:0] instr_count;

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .mem_ready(mem_ready), .halt(halt), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .reg_write(reg_write),
        .pc_write(pc_write), .state(state), .bus_err(bus_err), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  sb;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] exp_cnt = '0;
    logic        exp_err = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected observation for that cycle goes to the scoreboard
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic hlt, input logic rs, input logic [2:0] est,
                       input logic [5:0] estr);
        @(negedge clock);
        Opcode = op;
        Function_opcode = fn;
        mem_ready = rdy;
        halt = hlt;
        reset = rs;
        if (rs) begin
            exp_cnt = '0;
            exp_err = 1'b0;
        end
        sb_q.push_back('{st: est, sb: estr, cnt: exp_cnt, err: exp_err});
        if (estr[0]) exp_cnt = exp_cnt + 32'd1;
    endtask

    // Strobe order: {mem_read, mem_write, mem_addr_sel, ir_write, reg_write, pc_write}
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int kind,
                            input int fw, input int mw);
        for (int i = 0; i < fw; i++) cyc(op, fn, 1'b0, 1'b0, 1'b0, 3'd0, 6'b100000);
        cyc(op, fn, 1'b1, 1'b0, 1'b0, 3'd0, 6'b100100);
        if (kind == K_JMP) begin
            cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd1, 6'b000001);
        end else if (kind == K_JAL) begin
            cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd1, 6'b000000);
            cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd4, 6'b000011);
        end else begin
            cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd1, 6'b000000);
            if (kind == K_BR) begin
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd2, 6'b000001);
            end else if (kind == K_ALU) begin
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd2, 6'b000000);
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd4, 6'b000011);
            end else if (kind == K_LW) begin
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd2, 6'b000000);
                for (int i = 0; i < mw; i++) cyc(op, fn, 1'b0, 1'($urandom), 1'b0, 3'd3, 6'b101000);
                cyc(op, fn, 1'b1, 1'($urandom), 1'b0, 3'd3, 6'b101000);
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd4, 6'b000011);
            end else begin
                cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, 3'd2, 6'b000000);
                for (int i = 0; i < mw; i++) cyc(op, fn, 1'b0, 1'($urandom), 1'b0, 3'd3, 6'b011000);
                cyc(op, fn, 1'b1, 1'($urandom), 1'b0, 3'd3, 6'b011001);
            end
        end
    endtask

    // Scoreboard consumer: compare each cycle's DUT outputs against the queued expectation
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("state", 32'(state), 32'(mon_e.st));
                check("strobes", 32'({mem_read, mem_write, mem_addr_sel, ir_write, reg_write, pc_write}),
                      32'(mon_e.sb));
                check("instr_count", instr_count, mon_e.cnt);
                check("bus_err", 32'(bus_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, strobes gated even though FETCH would request
        cyc(6'h00, 6'h20, 1'b1, 1'b0, 1'b1, 3'd0, 6'b000000);
        cyc(6'h00, 6'h20, 1'b1, 1'b0, 1'b1, 3'd0, 6'b000000);

        // R-type add back to back
        for (int i = 0; i < 3; i++) do_instr(6'h00, 6'h20, K_ALU, 0, 0);
        // lw with 3 wait cycles in MEM, then lw with fetch waits
        do_instr(6'h23, 6'h00, K_LW, 0, 3);
        do_instr(6'h23, 6'h11, K_LW, 2, 0);
        // control flow, jal, unknown, branches, I-format, sw
        do_instr(6'h02, 6'h00, K_JMP, 0, 0);
        do_instr(6'h00, 6'h08, K_JMP, 1, 0);
        do_instr(6'h03, 6'h00, K_JAL, 0, 0);
        do_instr(6'h3F, 6'h00, K_JMP, 0, 0);
        do_instr(6'h04, 6'h00, K_BR, 0, 0);
        do_instr(6'h05, 6'h00, K_BR, 3, 0);
        do_instr(6'h08, 6'h00, K_ALU, 0, 0);
        do_instr(6'h0D, 6'h00, K_ALU, 0, 0);
        do_instr(6'h2B, 6'h00, K_SW, 0, 2);

        // halt longer than the timeout window: idle, no error, then a normal fetch
        for (int i = 0; i < 20; i++) cyc(6'h00, 6'h20, 1'b0, 1'b1, 1'b0, 3'd0, 6'b000000);
        do_instr(6'h00, 6'h20, K_ALU, 0, 0);

        // last allowed wait cycle is accepted in both FETCH and MEM
        do_instr(6'h00, 6'h22, K_ALU, 15, 0);
        do_instr(6'h23, 6'h00, K_LW, 0, 15);
        do_instr(6'h2B, 6'h00, K_SW, 0, 15);

        // reset in the middle of a sw memory access
        cyc(6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 6'b100100);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd1, 6'b000000);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd2, 6'b000000);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd3, 6'b011000);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd3, 6'b011000);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, 6'b000000);
        do_instr(6'h00, 6'h20, K_ALU, 1, 0);

        // sw with memory never ready: 16 request cycles, then absorbing ERR
        cyc(6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 6'b100100);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd1, 6'b000000);
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd2, 6'b000000);
        for (int i = 0; i < 16; i++) cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 3'd3, 6'b011000);
        exp_err = 1'b1;
        for (int i = 0; i < 6; i++)
            cyc(6'h2B, 6'h00, 1'($urandom), 1'($urandom), 1'b0, 3'd7, 6'b000000);
        cyc(6'h2B, 6'h00, 1'b1, 1'b0, 1'b1, 3'd0, 6'b000000);
        do_instr(6'h00, 6'h20, K_ALU, 0, 0);

        // fetch never ready: times out from FETCH as well
        for (int i = 0; i < 16; i++) cyc(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 3'd0, 6'b100000);
        exp_err = 1'b1;
        cyc(6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 3'd7, 6'b000000);
        cyc(6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 3'd7, 6'b000000);

        @(negedge clock);
        #3;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
